cr_tlvp_usr_ob_arb: RTL

Round-robin arbiter that shares the single user-outbound TLV write port of the TLV parser (usr_wr/usr_tlv, with usr_full/usr_afull backpressure) among N_REQ requester FIFOs.
- Grants at TLV granularity: once a requester wins, it is held until the word carrying eot has been read, so TLVs never interleave.
- Sits between per-engine TLV output FIFOs and the parser user-outbound port, inside each engine top.

---
 rtl/cr_tlvp_usr_ob_arb_pkg.sv | 20 ++
 rtl/cr_tlvp_usr_ob_arb_rr_pick.sv | 23 ++
 rtl/cr_tlvp_usr_ob_arb.sv | 130 +++++++++++++
 3 files changed

// File: rtl/cr_tlvp_usr_ob_arb_pkg.sv
// Shared types for the TLV user-outbound arbiter: bus word, FSM states, stall counter width.
package cr_tlvp_arb_pkg;

  localparam int STALL_CW = 8;
  localparam int TLV_DW   = 32;

  typedef enum logic {IDLE = 1'b0, LOCK = 1'b1} tlvp_arb_state_e;

  typedef struct packed {
    logic              sot;
    logic              eot;
    logic [7:0]        typ;
    logic [TLV_DW-1:0] tdata;
  } tlvp_if_bus_t;

  function automatic logic [STALL_CW-1:0] sat_inc(input logic [STALL_CW-1:0] v);
    return (&v) ? v : v + 1'b1;
  endfunction

endpackage

// File: rtl/cr_tlvp_usr_ob_arb_rr_pick.sv
// Combinational round-robin selector: first set request at or after ptr, wrapping.
module cr_rr_pick #(
  parameter int N  = 4,
  parameter int PW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req_i,
  input  logic [PW-1:0] ptr_i,
  output logic [N-1:0]  gnt_o,
  output logic          vld_o
);

  always_comb begin
    gnt_o = '0;
    vld_o = 1'b0;
    for (int k = 0; k < N; k++) begin
      if (!vld_o && req_i[(int'(ptr_i) + k) % N]) begin
        gnt_o[(int'(ptr_i) + k) % N] = 1'b1;
        vld_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/cr_tlvp_usr_ob_arb.sv
// Round-robin TLV-granular arbiter onto the parser user-outbound port.
// Optional per-requester TLV counters under CR_TLVP_USR_OB_ARB_STATS_EN.
module cr_tlvp_usr_ob_arb
  import cr_tlvp_arb_pkg::*;
#(
  parameter int N_REQ       = 4,
  parameter int STALL_LIMIT = 255
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic [N_REQ-1:0]         req_empty,
  input  tlvp_if_bus_t [N_REQ-1:0] req_tlv,
  output logic [N_REQ-1:0]         req_rd,
  input  logic                     usr_full,
  input  logic                     usr_afull,
  output logic                     usr_wr,
  output tlvp_if_bus_t             usr_tlv,
  output logic [N_REQ-1:0]         cur_grant,
  output logic                     stall_err,
  output logic                     ovf_err
`ifdef CR_TLVP_USR_OB_ARB_STATS_EN
  ,
  input  logic                     stats_clr,
  output logic [N_REQ-1:0][15:0]   tlv_cnt
`endif
);

  localparam int PW = $clog2(N_REQ);

  tlvp_arb_state_e     state_q, state_d;
  logic [PW-1:0]       rr_ptr_q, rr_ptr_d, gidx_q, gidx_d, pop_idx;
  logic [STALL_CW-1:0] stall_cnt_q, stall_cnt_d;
  logic                stall_err_q, ovf_err_q, usr_wr_q;
  tlvp_if_bus_t        usr_tlv_q, pop_word;
  logic [N_REQ-1:0]    pick_gnt;
  logic                pick_vld, pop, pop_eot, starve;

  cr_rr_pick #(.N(N_REQ), .PW(PW)) u_pick (
    .req_i (~req_empty),
    .ptr_i (rr_ptr_q),
    .gnt_o (pick_gnt),
    .vld_o (pick_vld)
  );

  // In IDLE the grant is visible only in the cycle it pops; in LOCK it is held.
  always_comb begin
    req_rd    = '0;
    cur_grant = '0;
    pop_idx   = gidx_q;
    if (state_q == IDLE) begin
      if (pick_vld && !usr_afull) req_rd = pick_gnt;
      for (int i = 0; i < N_REQ; i++)
        if (pick_gnt[i]) pop_idx = PW'(i);
      cur_grant = req_rd;
    end else begin
      req_rd[gidx_q]    = !req_empty[gidx_q] && !usr_afull;
      cur_grant[gidx_q] = 1'b1;
    end
  end

  assign pop      = |req_rd;
  assign pop_word = req_tlv[pop_idx];
  assign pop_eot  = pop && pop_word.eot;
  // Held-off by afull is backpressure, not starvation.
  assign starve   = (state_q == LOCK) && req_empty[gidx_q] && !usr_afull;

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    gidx_d      = gidx_q;
    stall_cnt_d = stall_cnt_q;
    if (state_q == IDLE && pop) begin
      gidx_d = pop_idx;
      if (!pop_word.eot) state_d = LOCK;
    end
    if (pop_eot) begin
      state_d  = IDLE;
      rr_ptr_d = (pop_idx == PW'(N_REQ - 1)) ? '0 : pop_idx + 1'b1;
    end
    if (state_q == IDLE || pop) stall_cnt_d = '0;
    else if (starve)            stall_cnt_d = sat_inc(stall_cnt_q);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      gidx_q      <= '0;
      stall_cnt_q <= '0;
      stall_err_q <= 1'b0;
      ovf_err_q   <= 1'b0;
      usr_wr_q    <= 1'b0;
      usr_tlv_q   <= '0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      gidx_q      <= gidx_d;
      stall_cnt_q <= stall_cnt_d;
      stall_err_q <= stall_err_q | (starve && (stall_cnt_d == STALL_CW'(STALL_LIMIT)));
      ovf_err_q   <= ovf_err_q | (usr_wr_q & usr_full);
      usr_wr_q    <= pop;
      if (pop) usr_tlv_q <= pop_word;
    end
  end

  assign usr_wr    = usr_wr_q;
  assign usr_tlv   = usr_tlv_q;
  assign stall_err = stall_err_q;
  assign ovf_err   = ovf_err_q;

`ifdef CR_TLVP_USR_OB_ARB_STATS_EN
  logic [N_REQ-1:0][15:0] tlv_cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tlv_cnt_q <= '0;
    end else begin
      for (int i = 0; i < N_REQ; i++) begin
        if (stats_clr)
          tlv_cnt_q[i] <= '0;
        else if (pop_eot && pop_idx == PW'(i) && !(&tlv_cnt_q[i]))
          tlv_cnt_q[i] <= tlv_cnt_q[i] + 16'd1;
      end
    end
  end

  assign tlv_cnt = tlv_cnt_q;
`endif

endmodule
